alu_op_sequencer: RTL and testbench

Controller that drives the shared 4-bit ALU datapath through all eight opcodes for one operand pair and captures each result. On `start` it latches `a`/`b` and sweeps `op_sel` 0..7, holding each opcode for a programmable dwell time so the combinational datapath settles. It stores each 4-bit result in an internal result bank and pulses `done`. It sits between the operand switches and the ALU/display logic, and replaces the free-running 3-bit opcode counter with a start/done handshake.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_seq_dwell_cnt.sv | 27 ++
 rtl/alu_op_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state, sweep size and opcode constants
// for the ALU opcode sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_OPS = 8;

  localparam logic [2:0] OP_SOM = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

endpackage

// File: rtl/alu_seq_dwell_cnt.sv
// alu_seq_dwell_cnt: 8-bit dwell counter with clear, enable
// and terminal count at DWELL-1; wraps to 0 on terminal count.
module alu_seq_dwell_cnt #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'(DWELL - 1);

  logic [7:0] cnt;

  assign tc = (cnt == TC_VAL);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sweeps the ALU through all opcodes for one
// operand pair. Optional ALU_SEQ_PAUSE_EN adds a pause input.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef ALU_SEQ_PAUSE_EN
  input  logic       pause,
`endif
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic [3:0] alu_s,
  input  logic       alu_cout_som,
  input  logic       alu_cout_sub,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic [2:0] op_sel,
  output logic       busy,
  output logic       done,
  input  logic [2:0] rd_addr,
  output logic [3:0] rd_data,
  output logic       cout_som_q,
  output logic       cout_sub_q
);

  localparam logic [2:0] LAST_OP = 3'(NUM_OPS - 1);

  state_t state;
  state_t nxt;

  logic       hold;
  logic       run_en;
  logic       tc;
  logic       cap;
  logic       last;
  logic       go;
  logic [3:0] bank [NUM_OPS];

`ifdef ALU_SEQ_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign go     = (state == IDLE) && start;
  assign run_en = (state == RUN) && !hold;
  assign cap    = run_en && tc;
  assign last   = (op_sel == LAST_OP);

  alu_seq_dwell_cnt #(
    .DWELL (DWELL)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (go),
    .en  (run_en),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = RUN;
      RUN:  if (cap && last) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:  busy = 1'b1;
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // op_sel parks at the last opcode after a sweep until restarted
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out      <= '0;
      b_out      <= '0;
      op_sel     <= '0;
      cout_som_q <= 1'b0;
      cout_sub_q <= 1'b0;
      for (int i = 0; i < NUM_OPS; i++) begin
        bank[i] <= '0;
      end
    end else begin
      if (go) begin
        a_out  <= a_in;
        b_out  <= b_in;
        op_sel <= OP_SOM;
      end
      if (cap) begin
        bank[op_sel] <= alu_s;
        if (op_sel == OP_SOM) cout_som_q <= alu_cout_som;
        if (op_sel == OP_SUB) cout_sub_q <= alu_cout_sub;
        if (!last) op_sel <= op_sel + 3'd1;
      end
    end
  end

  assign rd_data = bank[rd_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: table-driven sweeps with a result scoreboard,
// plus DWELL=1, back-to-back, reset and pause corner cases.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start4 = 1'b0;
  logic       start1 = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] a_in = '0;
  logic [3:0] b_in = '0;
  logic [2:0] rd_addr = '0;

  logic [3:0] a4, b4, s4, rd4;
  logic [2:0] op4;
  logic       cs4, cb4, busy4, done4, csq4, cbq4;
  logic [3:0] a1, b1, s1, rd1;
  logic [2:0] op1;
  logic       cs1, cb1, busy1, done1, csq1, cbq1;

  int total = 0;
  int bad = 0;

  logic [3:0] exp_q[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] r [8];
    logic       cs;
    logic       cb;
  } vec_t;

  vec_t vt [4];

  always #5 clk = ~clk;

  // reference 4-bit ALU datapath: {cout_som, cout_sub, s}
  function automatic logic [5:0] alu(input logic [3:0] a,
                                     input logic [3:0] b,
                                     input logic [2:0] op);
    logic [4:0] sum;
    logic [3:0] s;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      3'd0: s = sum[3:0];
      3'd1: s = a - b;
      3'd2: s = {a[2:0], 1'b0};
      3'd3: s = {1'b0, a[3:1]};
      3'd4: s = a | b;
      3'd5: s = a & b;
      3'd6: s = a ^ b;
      default: s = ~a;
    endcase
    return {sum[4], (a >= b), s};
  endfunction

  always_comb {cs4, cb4, s4} = alu(a4, b4, op4);
  always_comb {cs1, cb1, s1} = alu(a1, b1, op1);

  alu_op_sequencer #(.DWELL(4)) u4 (
    .clk          (clk),
    .rst          (rst),
    .start        (start4),
`ifdef ALU_SEQ_PAUSE_EN
    .pause        (pause),
`endif
    .a_in         (a_in),
    .b_in         (b_in),
    .alu_s        (s4),
    .alu_cout_som (cs4),
    .alu_cout_sub (cb4),
    .a_out        (a4),
    .b_out        (b4),
    .op_sel       (op4),
    .busy         (busy4),
    .done         (done4),
    .rd_addr      (rd_addr),
    .rd_data      (rd4),
    .cout_som_q   (csq4),
    .cout_sub_q   (cbq4)
  );

  alu_op_sequencer #(.DWELL(1)) u1 (
    .clk          (clk),
    .rst          (rst),
    .start        (start1),
`ifdef ALU_SEQ_PAUSE_EN
    .pause        (1'b0),
`endif
    .a_in         (a_in),
    .b_in         (b_in),
    .alu_s        (s1),
    .alu_cout_som (cs1),
    .alu_cout_sub (cb1),
    .a_out        (a1),
    .b_out        (b1),
    .op_sel       (op1),
    .busy         (busy1),
    .done         (done1),
    .rd_addr      (rd_addr),
    .rd_data      (rd1),
    .cout_som_q   (csq1),
    .cout_sub_q   (cbq1)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input int v);
    for (int i = 0; i < 8; i++) exp_q.push_back(vt[v].r[i]);
  endtask

  // pop expected bank contents and compare against the chosen instance
  task automatic drain(input string name, input bit use1);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] e;
      rd_addr = 3'(i);
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s bank[%0d]", name, i),
            use1 ? int'(rd1) : int'(rd4), int'(e));
    end
  endtask

  // start a DWELL=4 sweep; n counts edges from the start edge to done
  task automatic sweep4(input logic [3:0] a, input logic [3:0] b,
                        input bit do_pause, output int n);
    bit paused;
    paused = 1'b0;
    a_in = a;
    b_in = b;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 400) begin
      tick();
      n++;
      if (do_pause && !paused && op4 == 3'd3 && !done4) begin
        pause = 1'b1;
        repeat (5) begin
          tick();
          n++;
        end
        pause = 1'b0;
        paused = 1'b1;
      end
    end
  endtask

  initial begin
    int n;
    int nd;
    int first;
    int d [3];

    vt[0].a = 4'd5;  vt[0].b = 4'd3;
    vt[0].r = '{4'd8, 4'd2, 4'd10, 4'd2, 4'd7, 4'd1, 4'd6, 4'd10};
    vt[0].cs = 1'b0; vt[0].cb = 1'b1;
    vt[1].a = 4'd15; vt[1].b = 4'd1;
    vt[1].r = '{4'd0, 4'd14, 4'd14, 4'd7, 4'd15, 4'd1, 4'd14, 4'd0};
    vt[1].cs = 1'b1; vt[1].cb = 1'b1;
    vt[2].a = 4'd2;  vt[2].b = 4'd9;
    vt[2].r = '{4'd11, 4'd9, 4'd4, 4'd1, 4'd11, 4'd0, 4'd11, 4'd13};
    vt[2].cs = 1'b0; vt[2].cb = 1'b0;
    vt[3].a = 4'd12; vt[3].b = 4'd12;
    vt[3].r = '{4'd8, 4'd0, 4'd8, 4'd6, 4'd12, 4'd12, 4'd0, 4'd3};
    vt[3].cs = 1'b1; vt[3].cb = 1'b1;

    repeat (3) tick();
    rst = 1'b0;
    rd_addr = 3'd0;
    #1;
    check("rst busy", int'(busy4), 0);
    check("rst done", int'(done4), 0);
    check("rst op_sel", int'(op4), 0);
    check("rst a_out", int'(a4), 0);
    check("rst cout_som", int'(csq4), 0);
    check("rst bank0", int'(rd4), 0);

    for (int v = 0; v < 4; v++) begin
      push_vec(v);
      sweep4(vt[v].a, vt[v].b, 1'b0, n);
      check($sformatf("v%0d latency", v), n, 32);
      drain($sformatf("v%0d", v), 1'b0);
      check($sformatf("v%0d cout_som", v), int'(csq4), int'(vt[v].cs));
      check($sformatf("v%0d cout_sub", v), int'(cbq4), int'(vt[v].cb));
      check($sformatf("v%0d op_hold", v), int'(op4), 7);
      tick();
      check($sformatf("v%0d idle", v), int'(done4 | busy4), 0);
    end

`ifdef ALU_SEQ_PAUSE_EN
    push_vec(0);
    sweep4(4'd5, 4'd3, 1'b1, n);
    check("pause latency", n, 37);
    drain("pause", 1'b0);
    tick();
`endif

    // DWELL=1: start pulses during RUN are ignored
    push_vec(0);
    a_in = 4'd5;
    b_in = 4'd3;
    start1 = 1'b1;
    tick();
    nd = 0;
    first = -1;
    for (int k = 0; k < 20; k++) begin
      start1 = (k <= 7) && k[0];
      if (k < 8) check($sformatf("d1 op_sel@%0d", k), int'(op1), k);
      if (done1) begin
        nd++;
        if (first < 0) first = k;
      end
      tick();
    end
    start1 = 1'b0;
    check("d1 done count", nd, 1);
    check("d1 done time", first, 8);
    drain("d1", 1'b1);

    // back-to-back with start held high
    d = '{-100, -100, -100};
    nd = 0;
    start1 = 1'b1;
    tick();
    for (int k = 0; k < 60 && nd < 3; k++) begin
      if (done1) begin
        d[nd] = k;
        nd++;
      end
      tick();
    end
    start1 = 1'b0;
    check("b2b first", d[0], 8);
    check("b2b period1", d[1] - d[0], 10);
    check("b2b period2", d[2] - d[1], 10);
    repeat (15) tick();

    // mid-sweep operand change, then reset at cycle 10
    a_in = 4'd5;
    b_in = 4'd3;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    a_in = 4'd9;
    tick();
    tick();
    check("freeze a_out", int'(a4), 5);
    check("freeze busy", int'(busy4), 1);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst busy", int'(busy4), 0);
    check("mrst op_sel", int'(op4), 0);
    check("mrst done", int'(done4), 0);
    check("mrst a_out", int'(a4), 0);
    check("mrst cout_som", int'(csq4), 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(4'd0);
    drain("mrst", 1'b0);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (done4 || busy4) nd++;
      tick();
    end
    check("mrst no done", nd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
